// File: rtl/fp_add_arbiter.sv
// ---------------------------------------------------------------------------
// fp_add_arbiter
//
// Round-robin scheduler sharing one pipelined fp32 adder among N_REQ
// requesters. At most one request is granted per cycle. The granted
// operands go straight to the adder. A LAT-deep tag pipeline carries the
// requester ID alongside each operation, so the adder result returns to the
// requester that issued it, in issue order.
//
// Parameters
//   N_REQ  number of requesters (>= 2)
//   LAT    adder latency in cycles, add_en -> add_sum (>= 1)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   hold       suppresses new grants; in-flight operations still retire
//   req_valid  per-requester request flag
//   req_a/b    packed operands, requester i at [32i+31:32i]
//   req_ready  one-hot grant (combinational, same cycle as the request)
//   add_en     issue strobe to the adder
//   add_a/b    operands of the granted requester, 0 when idle
//   add_sum    adder result, valid LAT cycles after add_en
//   rsp_valid  one-hot retire strobe
//   rsp_id     binary ID of the retiring requester, 0 when idle
//   rsp_sum    add_sum while retiring, else 0
//   inflight   issued but not yet retired operations
//   busy       inflight != 0
// ---------------------------------------------------------------------------
module fp_add_arbiter #(
  parameter  int N_REQ = 4,
  parameter  int LAT   = 5,
  localparam int ID_W  = $clog2(N_REQ),
  localparam int CNT_W = $clog2(LAT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*32-1:0]  req_a,
  input  logic [N_REQ*32-1:0]  req_b,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 add_en,
  output logic [31:0]          add_a,
  output logic [31:0]          add_b,
  input  logic [31:0]          add_sum,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [31:0]          rsp_sum,
  output logic [CNT_W-1:0]     inflight,
  output logic                 busy
);

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  cand;
  logic             gnt;
  logic [ID_W-1:0]  gnt_id;

  logic [LAT-1:0]   tag_v;
  logic [ID_W-1:0]  tag_id [LAT];
  logic             retire;
  logic             rsp_live;

  // -------------------------------------------------------------------------
  // Arbitration: scan from rr_ptr and wrap. The first valid requester wins.
  // -------------------------------------------------------------------------
  // NOTE: every signal written here gets a default before the search, so the
  // block is purely combinational and no latch is inferred.
  always_comb begin
    gnt    = 1'b0;
    gnt_id = '0;
    cand   = '0;
    if (!rst && !hold) begin
      for (int off = 0; off < N_REQ; off++) begin
        cand = ID_W'((int'(rr_ptr) + off) % N_REQ);
        if (!gnt && req_valid[cand]) begin
          gnt    = 1'b1;
          gnt_id = cand;
        end
      end
    end
  end

  always_comb begin
    req_ready = gnt ? (N_REQ'(1) << gnt_id) : '0;
    add_en    = gnt;
    add_a     = gnt ? req_a[32*gnt_id +: 32] : '0;
    add_b     = gnt ? req_b[32*gnt_id +: 32] : '0;
  end

  // -------------------------------------------------------------------------
  // Round-robin pointer: after a grant it moves one past the winner.
  // Without a grant (including while held) it stays where it is.
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments. All registers then
  // update together at the edge, whatever order the blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (gnt) begin
      rr_ptr <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Tag pipeline mirrors the adder: stage LAT-1 lines up with add_sum.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v <= '0;
    end else begin
      tag_v[0] <= gnt;
      for (int k = 1; k < LAT; k++) tag_v[k] <= tag_v[k-1];
    end
  end

  // NOTE: the ID stages are deliberately left out of reset. They are only
  // observed through their valid bit, and that bit is cleared.
  always_ff @(posedge clk) begin
    tag_id[0] <= gnt_id;
    for (int k = 1; k < LAT; k++) tag_id[k] <= tag_id[k-1];
  end

  assign retire   = tag_v[LAT-1];
  // While rst is high the response side is forced quiet as well.
  assign rsp_live = retire && !rst;

  always_comb begin
    rsp_valid = rsp_live ? (N_REQ'(1) << tag_id[LAT-1]) : '0;
    rsp_id    = rsp_live ? tag_id[LAT-1] : '0;
    rsp_sum   = rsp_live ? add_sum : '0;
  end

  // -------------------------------------------------------------------------
  // In-flight counter. Issue and retire in the same cycle cancel out.
  // The tag pipeline holds at most LAT entries, so the count cannot exceed LAT.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({gnt, retire})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  assign busy = !rst && (inflight != '0);

endmodule

// File: tb/tb_fp_add_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fp_add_arbiter
//
// Self-checking bench for fp_add_arbiter (N_REQ=4, LAT=5).
// The bench holds a per-cycle table of {rst, hold, req_valid, expected grant,
// expected response, expected inflight}. Each row drives one cycle. Operands
// are fixed per requester, so the expected operands and sums follow from the
// expected grant and response. A LAT-cycle delay-line adder model supplies
// add_sum. It shows 0xDEADBEEF when no result is due, which exposes an ungated
// rsp_sum. A few hand-written sequences cover hold and the exact latency.
// ---------------------------------------------------------------------------
module tb_fp_add_arbiter;

  localparam int N_REQ = 4;
  localparam int LAT   = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic                hold;
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*32-1:0] req_a;
  logic [N_REQ*32-1:0] req_b;
  logic [N_REQ-1:0]    req_ready;
  logic                add_en;
  logic [31:0]         add_a;
  logic [31:0]         add_b;
  logic [31:0]         add_sum;
  logic [N_REQ-1:0]    rsp_valid;
  logic [1:0]          rsp_id;
  logic [31:0]         rsp_sum;
  logic [2:0]          inflight;
  logic                busy;

  fp_add_arbiter #(.N_REQ(N_REQ), .LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .hold      (hold),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .add_en    (add_en),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .inflight  (inflight),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // ----------------------------- adder model -------------------------------
  // fp32 <-> real conversion that is exact for the normal values used here.
  function automatic real f32_to_real(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:0] == 31'b0) return 0.0;
    d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real_to_f32(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == 63'b0) return {d[63], 31'b0};
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  logic        pv [LAT] = '{default: 1'b0};
  logic [31:0] ps [LAT] = '{default: 32'h0};

  always @(posedge clk) begin
    pv[0] <= add_en;
    ps[0] <= real_to_f32(f32_to_real(add_a) + f32_to_real(add_b));
    for (int k = 1; k < LAT; k++) begin
      pv[k] <= pv[k-1];
      ps[k] <= ps[k-1];
    end
  end

  assign add_sum = pv[LAT-1] ? ps[LAT-1] : 32'hDEADBEEF;

  // ----------------------------- checking ----------------------------------
  int n_cmp  = 0;
  int n_fail = 0;
  int row    = -1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (row %0d): got %h, expected %h", name, row, act, exp);
    end
  endtask

  // Operands: a = 1.0, 2.0, 3.0, 4.0 and b = 2.0, so the sums are 3, 4, 5, 6.
  logic [31:0] a_tab   [N_REQ] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
  localparam logic [31:0] B_VAL = 32'h40000000;
  logic [31:0] sum_tab [N_REQ] = '{32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};

  function automatic int oh_to_id(input logic [3:0] oh);
    for (int i = 0; i < N_REQ; i++) if (oh[i]) return i;
    return 0;
  endfunction

  typedef struct {
    logic       rst;
    logic       hold;
    logic [3:0] v;
    logic [3:0] rdy;
    logic [3:0] rsp;
    int         f;
  } vec_t;

  vec_t vecs[$];

  localparam logic [3:0] Z  = 4'b0000;
  localparam logic [3:0] AL = 4'b1111;

  function automatic void add(input logic r, input logic h, input logic [3:0] v,
                              input logic [3:0] rdy, input logic [3:0] rsp,
                              input int f);
    vec_t e;
    e.rst = r; e.hold = h; e.v = v; e.rdy = rdy; e.rsp = rsp; e.f = f;
    vecs.push_back(e);
  endfunction

  initial begin
    // Reset: all outputs quiet even with every request raised.
    add(1'b1, 1'b0, AL, Z, Z, 0);
    // Single request: grant now, response 5 cycles later, inflight 1 then 0.
    add(1'b0, 1'b0, 4'b0001, 4'b0001, Z, 0);
    for (int c = 0; c < 4; c++) add(1'b0, 1'b0, Z, Z, Z, 1);
    add(1'b0, 1'b0, Z, Z, 4'b0001, 1);
    add(1'b0, 1'b0, Z, Z, Z, 0);
    // Simultaneous requests 1 and 3 from rr_ptr = 0.
    add(1'b1, 1'b0, Z, Z, Z, 0);
    add(1'b0, 1'b0, 4'b1010, 4'b0010, Z, 0);
    add(1'b0, 1'b0, 4'b1000, 4'b1000, Z, 1);
    for (int c = 0; c < 3; c++) add(1'b0, 1'b0, Z, Z, Z, 2);
    add(1'b0, 1'b0, Z, Z, 4'b0010, 2);
    add(1'b0, 1'b0, Z, Z, 4'b1000, 1);
    add(1'b0, 1'b0, Z, Z, Z, 0);
    // Saturation: 16 cycles of all requesters, then drain.
    for (int c = 0; c < 16; c++)
      add(1'b0, 1'b0, AL, 4'b0001 << (c % 4),
          (c >= 5) ? (4'b0001 << ((c - 5) % 4)) : Z, (c < 5) ? c : 5);
    for (int c = 16; c < 21; c++)
      add(1'b0, 1'b0, Z, Z, 4'b0001 << ((c - 5) % 4), 21 - c);
    add(1'b0, 1'b0, Z, Z, Z, 0);
    // Hold: grant, 4 held cycles, regrant on the retire cycle.
    add(1'b0, 1'b0, 4'b0100, 4'b0100, Z, 0);
    for (int c = 0; c < 4; c++) add(1'b0, 1'b1, 4'b0100, Z, Z, 1);
    add(1'b0, 1'b0, 4'b0100, 4'b0100, 4'b0100, 1);
    for (int c = 0; c < 4; c++) add(1'b0, 1'b0, Z, Z, Z, 1);
    add(1'b0, 1'b0, Z, Z, 4'b0100, 1);
    add(1'b0, 1'b0, Z, Z, Z, 0);
    // Reset mid-flight (rr_ptr = 3): three issues, reset, silence, restart at 0.
    add(1'b0, 1'b0, AL, 4'b1000, Z, 0);
    add(1'b0, 1'b0, AL, 4'b0001, Z, 1);
    add(1'b0, 1'b0, AL, 4'b0010, Z, 2);
    add(1'b1, 1'b0, AL, Z, Z, 3);
    for (int c = 0; c < 5; c++) add(1'b0, 1'b0, Z, Z, Z, 0);
    add(1'b0, 1'b0, AL, 4'b0001, Z, 0);
    for (int c = 0; c < 4; c++) add(1'b0, 1'b0, Z, Z, Z, 1);
    add(1'b0, 1'b0, Z, Z, 4'b0001, 1);
    add(1'b0, 1'b0, Z, Z, Z, 0);
    // Sole requester 3, six back-to-back grants and six responses.
    for (int c = 0; c < 6; c++)
      add(1'b0, 1'b0, 4'b1000, 4'b1000, (c == 5) ? 4'b1000 : Z, c);
    for (int c = 6; c < 11; c++)
      add(1'b0, 1'b0, Z, Z, 4'b1000, (c == 6) ? 5 : 11 - c);
    add(1'b0, 1'b0, Z, Z, Z, 0);

    // --------------------------- apply table -------------------------------
    rst       = 1'b1;
    hold      = 1'b0;
    req_valid = '0;
    req_a     = {a_tab[3], a_tab[2], a_tab[1], a_tab[0]};
    req_b     = {4{B_VAL}};
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      vec_t e;
      e         = vecs[i];
      row       = i;
      rst       = e.rst;
      hold      = e.hold;
      req_valid = e.v;
      @(negedge clk);
      check("req_ready", req_ready, e.rdy);
      check("add_en",    add_en,    e.rdy != Z);
      check("add_a",     add_a,     (e.rdy != Z) ? a_tab[oh_to_id(e.rdy)] : 32'h0);
      check("add_b",     add_b,     (e.rdy != Z) ? B_VAL : 32'h0);
      check("rsp_valid", rsp_valid, e.rsp);
      check("rsp_id",    rsp_id,    oh_to_id(e.rsp));
      check("rsp_sum",   rsp_sum,   (e.rsp != Z) ? sum_tab[oh_to_id(e.rsp)] : 32'h0);
      if (!e.rst) check("inflight", inflight, e.f);
      check("busy",      busy,      !e.rst && (e.f != 0));
      @(posedge clk);
      #1;
    end

    // ------------------------ hand-written sequences ------------------------
    // rr_ptr is 0 here. Hold with every request raised grants nothing.
    row       = -1;
    rst       = 1'b0;
    hold      = 1'b1;
    req_valid = AL;
    @(negedge clk);
    check("hold_ready", req_ready, Z);
    check("hold_add_a", add_a, 32'h0);
    @(posedge clk);
    #1;

    // New operands on requester 1: 1.5 + 1.5 = 3.0, exactly LAT cycles later.
    hold            = 1'b0;
    req_valid       = 4'b0010;
    req_a[63:32]    = 32'h3FC00000;
    req_b[63:32]    = 32'h3FC00000;
    @(negedge clk);
    check("hs_ready", req_ready, 4'b0010);
    check("hs_add_a", add_a, 32'h3FC00000);
    check("hs_add_b", add_b, 32'h3FC00000);
    @(posedge clk);
    #1;
    req_valid = Z;
    for (int k = 1; k < LAT; k++) begin
      @(negedge clk);
      check("hs_rsp_early", rsp_valid, Z);
      check("hs_sum_early", rsp_sum, 32'h0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("hs_rsp_valid", rsp_valid, 4'b0010);
    check("hs_rsp_id",    rsp_id, 2'd1);
    check("hs_rsp_sum",   rsp_sum, 32'h40400000);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("hs_rsp_once",  rsp_valid, Z);
    check("hs_inflight",  inflight, 3'd0);
    check("hs_busy",      busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
